// File: rtl/cc_vec_sel_pkg.sv
// Shared definitions for the coordinate-vector selector: FSM encoding and slice helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_vec_sel_pkg;

  // Output stage state: empty, one beat held, one beat held plus one stored request.
  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_FULL      = 2'd1;
  localparam logic [1:0] ST_FULL_PEND = 2'd2;

  // Bit offset of source src, channel ch inside the flattened source bus.
  function automatic int unsigned vec_off(input int unsigned src, input int unsigned ch,
                                          input int unsigned n_ch, input int unsigned data_w);
    return (src * n_ch + ch) * data_w;
  endfunction

endpackage

// File: rtl/cc_vec_sel_if.sv
// Bundle of the selector's source-side inputs and output-beat signals.
// Latency: n/a (wiring only).
// Backpressure: ready from the consumer stalls the held beat; master drives inputs, slave is the selector.
interface cc_vec_sel_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 3,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = $clog2(N_SRC)
);
  logic [N_SRC*N_CH*DATA_W-1:0] CC_VECSEL_data_InBus;
  logic [N_SRC-1:0]             CC_VECSEL_present_InBus;
  logic                         CC_VECSEL_mode_InHigh;
  logic [SEL_W-1:0]             CC_VECSEL_select_InBus;
  logic                         CC_VECSEL_trig_InHigh;
  logic                         CC_VECSEL_ready_InHigh;
  logic [N_CH*DATA_W-1:0]       CC_VECSEL_data_OutBus;
  logic                         CC_VECSEL_valid_OutHigh;
  logic [SEL_W-1:0]             CC_VECSEL_index_OutBus;
  logic                         CC_VECSEL_wrap_OutHigh;
  logic                         CC_VECSEL_ovf_OutHigh;
  logic                         CC_VECSEL_none_OutHigh;

  modport master (
    output CC_VECSEL_data_InBus, CC_VECSEL_present_InBus, CC_VECSEL_mode_InHigh,
           CC_VECSEL_select_InBus, CC_VECSEL_trig_InHigh, CC_VECSEL_ready_InHigh,
    input  CC_VECSEL_data_OutBus, CC_VECSEL_valid_OutHigh, CC_VECSEL_index_OutBus,
           CC_VECSEL_wrap_OutHigh, CC_VECSEL_ovf_OutHigh, CC_VECSEL_none_OutHigh
  );

  modport slave (
    input  CC_VECSEL_data_InBus, CC_VECSEL_present_InBus, CC_VECSEL_mode_InHigh,
           CC_VECSEL_select_InBus, CC_VECSEL_trig_InHigh, CC_VECSEL_ready_InHigh,
    output CC_VECSEL_data_OutBus, CC_VECSEL_valid_OutHigh, CC_VECSEL_index_OutBus,
           CC_VECSEL_wrap_OutHigh, CC_VECSEL_ovf_OutHigh, CC_VECSEL_none_OutHigh
  );
endinterface

// File: rtl/cc_vec_sel_find_next.sv
// Cyclic priority search: first present source at or after ptr_i.
// Latency: combinational. Ports: present_i, ptr_i in; index_o, wrap_o, found_o out.
// Backpressure: none.
module cc_vec_sel_find_next #(
  parameter int N_SRC = 4,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] present_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] index_o,
  output logic             wrap_o,
  output logic             found_o
);

  int cand;

  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    cand    = 0;
    // Walk offsets from the far end down so the smallest offset from ptr wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N_SRC;
      if (present_i[cand]) begin
        index_o = SEL_W'(cand);
        found_o = 1'b1;
      end
    end
    // Wrapped if the search passed the top source, or the pointer will roll over to 0.
    wrap_o = found_o && ((index_o < ptr_i) || (index_o == SEL_W'(N_SRC - 1)));
  end

endmodule

// File: rtl/cc_vec_sel_reg.sv
// Registered N_SRC:1 selector of N_CH-channel vectors, manual or round-robin auto source choice.
// Latency: 1 cycle trigger-to-beat. Ports: clock, sync reset, cc_vec_sel_if.slave bus.
// Backpressure: beat held until ready; one request can wait pending, further triggers drop and set ovf.
module cc_vec_sel_reg
  import cc_vec_sel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 3,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input logic         CC_VECSEL_CLOCK_50,
  input logic         CC_VECSEL_RESET_InHigh,
  cc_vec_sel_if.slave bus
);

  logic [1:0]             state_q, state_d;
  logic [N_CH*DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]       index_q, index_d;
  logic                   wrap_q, wrap_d;
  logic [SEL_W-1:0]       pidx_q, pidx_d;
  logic                   pwrap_q, pwrap_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic                   ovf_q, ovf_d;
  logic                   none_q, none_d;

  logic [SEL_W-1:0] fn_idx, man_idx, req_idx, cap_idx;
  logic             fn_wrap, fn_found, req_wrap, req_ok, cap_wrap, capture, accept;

  cc_vec_sel_find_next #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_find (
    .present_i (bus.CC_VECSEL_present_InBus),
    .ptr_i     (ptr_q),
    .index_o   (fn_idx),
    .wrap_o    (fn_wrap),
    .found_o   (fn_found)
  );

  // Out-of-range manual selects fall back to source 0.
  assign man_idx  = (int'(bus.CC_VECSEL_select_InBus) >= N_SRC) ? '0 : bus.CC_VECSEL_select_InBus;
  assign req_idx  = bus.CC_VECSEL_mode_InHigh ? fn_idx : man_idx;
  assign req_wrap = bus.CC_VECSEL_mode_InHigh & fn_wrap;
  // An auto trigger with nothing present is not a request at all.
  assign req_ok   = bus.CC_VECSEL_trig_InHigh & (~bus.CC_VECSEL_mode_InHigh | fn_found);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    index_d  = index_q;
    wrap_d   = wrap_q;
    pidx_d   = pidx_q;
    pwrap_d  = pwrap_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    none_d   = none_q;
    capture  = 1'b0;
    accept   = 1'b0;
    cap_idx  = req_idx;
    cap_wrap = req_wrap;

    if (bus.CC_VECSEL_trig_InHigh && bus.CC_VECSEL_mode_InHigh && !fn_found) none_d = 1'b1;

    case (state_q)
      ST_EMPTY: begin
        if (req_ok) begin
          capture = 1'b1;
          accept  = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.CC_VECSEL_ready_InHigh) begin
          if (req_ok) begin
            capture = 1'b1;
            accept  = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (req_ok) begin
          pidx_d  = req_idx;
          pwrap_d = req_wrap;
          accept  = 1'b1;
          state_d = ST_FULL_PEND;
        end
      end
      ST_FULL_PEND: begin
        // Any new request here is dropped; the stored one is promoted when ready.
        if (req_ok) ovf_d = 1'b1;
        if (bus.CC_VECSEL_ready_InHigh) begin
          capture  = 1'b1;
          cap_idx  = pidx_q;
          cap_wrap = pwrap_q;
          state_d  = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Source words are sampled in the cycle the capture happens, including promotion.
    if (capture) begin
      data_d  = bus.CC_VECSEL_data_InBus[vec_off(32'(cap_idx), 0, N_CH, DATA_W) +: N_CH*DATA_W];
      index_d = cap_idx;
      wrap_d  = cap_wrap;
    end

    if (accept && bus.CC_VECSEL_mode_InHigh)
      ptr_d = (req_idx == SEL_W'(N_SRC - 1)) ? '0 : req_idx + SEL_W'(1);
  end

  always_ff @(posedge CC_VECSEL_CLOCK_50) begin
    if (CC_VECSEL_RESET_InHigh) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      index_q <= '0;
      wrap_q  <= 1'b0;
      pidx_q  <= '0;
      pwrap_q <= 1'b0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
      pidx_q  <= pidx_d;
      pwrap_q <= pwrap_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      none_q  <= none_d;
    end
  end

  assign bus.CC_VECSEL_data_OutBus   = data_q;
  assign bus.CC_VECSEL_valid_OutHigh = (state_q != ST_EMPTY);
  assign bus.CC_VECSEL_index_OutBus  = index_q;
  assign bus.CC_VECSEL_wrap_OutHigh  = wrap_q;
  assign bus.CC_VECSEL_ovf_OutHigh   = ovf_q;
  assign bus.CC_VECSEL_none_OutHigh  = none_q;

endmodule
